// File: rtl/array_20_pkg.sv
// array_20: shared widths and enums for the
// SRAM port arbiter and its response queue.
package array_20_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 96;
  localparam int MASK_W = 16;

  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic {RD, WR} grant_e;
endpackage

// File: rtl/array_20_resp_q.sv
// array_20: 2-entry read response FIFO
// between the SRAM read port and the consumer.
module array_20_resp_q
  import array_20_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_pop;

  assign valid  = count != 2'd0;
  assign head   = mem[rd_ptr];
  assign do_pop = pop & valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push}
                     - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  // Upstream credit check keeps pushes
  // away from a full queue.
  always_ff @(posedge clock) begin
    if (reset_n)
      assert (!(push && count == 2'd2));
  end

endmodule

// File: rtl/array_20_arb.sv
// array_20: owns the SRAM RW port, clears it after
// reset, round-robins reads and writes.
module array_20_arb
  import array_20_pkg::*;
#(
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [MASK_W-1:0] wr_req_mask,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              init_busy,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_e            state;
  state_e            state_nxt;
  grant_e            last_grant;
  logic [ADDR_W-1:0] init_cnt;
  logic              rd_pend;
  logic [1:0]        q_count;
  logic              pop;
  logic [2:0]        occ;
  logic              credit_ok;
  logic              run;
  logic              rd_elig;
  logic              wr_elig;
  logic              gnt_rd;
  logic              gnt_wr;

  assign init_busy = state == INIT;
  assign run       = reset_n & (state == RUN);
  assign pop       = rd_resp_valid & rd_resp_ready;

  // In-flight read plus queued entries must
  // leave room for one more response.
  assign occ = {1'b0, q_count}
             + {2'b0, rd_pend}
             - {2'b0, pop};
  assign credit_ok = occ < 3'd2;

  assign rd_elig = run & rd_req_valid & credit_ok;
  assign wr_elig = run & wr_req_valid;

  always_comb begin
    gnt_rd = rd_elig;
    gnt_wr = wr_elig;
    if (rd_elig && wr_elig) begin
      gnt_rd = last_grant == WR;
      gnt_wr = last_grant == RD;
    end
  end

  assign rd_req_ready = gnt_rd;
  assign wr_req_ready = gnt_wr;

  always_comb begin
    state_nxt = state;
    if (state == INIT && &init_cnt)
      state_nxt = RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= INIT_EN ? INIT : RUN;
      init_cnt   <= '0;
      last_grant <= WR;
      rd_pend    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init_busy)
        init_cnt <= init_cnt + ADDR_W'(1);
      if (gnt_rd)
        last_grant <= RD;
      else if (gnt_wr)
        last_grant <= WR;
      rd_pend <= gnt_rd;
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    unique case (1'b1)
      reset_n && init_busy: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
        sram_wmask = '1;
      end
      gnt_wr: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = wr_req_addr;
        sram_wmask = wr_req_mask;
        sram_wdata = wr_req_data;
      end
      gnt_rd: begin
        sram_en   = 1'b1;
        sram_addr = rd_req_addr;
      end
      default: ;
    endcase
  end

  array_20_resp_q u_resp_q (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_pend),
    .push_data (sram_rdata),
    .pop       (rd_resp_ready),
    .valid     (rd_resp_valid),
    .head      (rd_resp_data),
    .count     (q_count)
  );

endmodule

// File: tb/tb_array_20_arb.sv
// array_20_arb bench: SRAM macro model, reference
// model with per-cycle compare, directed scenarios.
module tb_array_20_arb;
  import array_20_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [MASK_W-1:0] wr_req_mask;
  logic [DATA_W-1:0] wr_req_data;
  logic              init_busy;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clock = ~clock;

  array_20_arb #(.INIT_EN(1'b1)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_mask   (wr_req_mask),
    .wr_req_data   (wr_req_data),
    .init_busy     (init_busy),
    .sram_en       (sram_en),
    .sram_wmode    (sram_wmode),
    .sram_addr     (sram_addr),
    .sram_wmask    (sram_wmask),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata)
  );

  function automatic logic [95:0] merge(
    input logic [95:0] old,
    input logic [15:0] mask,
    input logic [95:0] data);
    logic [95:0] r;
    r = old;
    for (int l = 0; l < 16; l++)
      if (mask[l]) r[l*6 +: 6] = data[l*6 +: 6];
    return r;
  endfunction

  // Macro behind the block: 1-cycle read latency.
  logic [95:0] sram [4096];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode)
        sram[sram_addr] <= merge(sram[sram_addr],
                                 sram_wmask, sram_wdata);
      else
        sram_rdata <= sram[sram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [95:0] d;
    int          t;
  } resp_t;

  resp_t       exp_q[$];
  logic [95:0] golden [int];
  bit          last_wr = 1'b1;
  int          init_left = 4096;
  int          cyc = 0;

  function automatic logic [95:0] gold_rd(input int a);
    return golden.exists(a) ? golden[a] : 96'h0;
  endfunction

  always @(negedge clock) begin : cmp
    bit busy, ev, epop, credit, re, we, erd, ewr;
    if (!reset_n) begin
      exp_q.delete();
      golden.delete();
      last_wr   = 1'b1;
      init_left = 4096;
    end else begin
      cyc++;
      busy   = init_left != 0;
      ev     = exp_q.size() != 0 && exp_q[0].t <= cyc;
      epop   = ev && rd_resp_ready;
      credit = (exp_q.size() - int'(epop)) < 2;
      re     = !busy && rd_req_valid && credit;
      we     = !busy && wr_req_valid;
      erd    = re && (!we || last_wr);
      ewr    = we && (!re || !last_wr);
      chk("init_busy", 96'(init_busy), 96'(busy));
      chk("rd_req_ready", 96'(rd_req_ready), 96'(erd));
      chk("wr_req_ready", 96'(wr_req_ready), 96'(ewr));
      chk("rd_resp_valid", 96'(rd_resp_valid), 96'(ev));
      if (ev)
        chk("rd_resp_data", rd_resp_data, exp_q[0].d);
      chk("sram_en", 96'(sram_en), 96'(busy || erd || ewr));
      if (busy) begin
        chk("sweep_addr", 96'(sram_addr), 96'(4096 - init_left));
        init_left--;
      end
      if (epop)
        void'(exp_q.pop_front());
      if (erd) begin
        exp_q.push_back('{gold_rd(int'(rd_req_addr)), cyc + 2});
        last_wr = 1'b0;
      end
      if (ewr) begin
        golden[int'(wr_req_addr)] =
          merge(gold_rd(int'(wr_req_addr)), wr_req_mask, wr_req_data);
        last_wr = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic count_init();
    int n = 0;
    bit done = 1'b0;
    bit first = 1'b1;
    while (!done && n < 5000) begin
      @(negedge clock);
      if (first)
        chk("sweep_start", 96'(sram_addr), 96'(0));
      first = 1'b0;
      if (init_busy) n++;
      else done = 1'b1;
    end
    chk("init_len", 96'(n), 96'(4096));
    tick();
  endtask

  task automatic do_write(input logic [11:0] a,
                          input logic [15:0] m,
                          input logic [95:0] d);
    int w = 0;
    bit g = 1'b0;
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_mask  = m;
    wr_req_data  = d;
    while (!g && w < 50) begin
      @(negedge clock);
      g = wr_req_ready;
      tick();
      w++;
    end
    wr_req_valid = 1'b0;
    chk("wr_grant", 96'(g), 96'(1));
  endtask

  task automatic do_read(input logic [11:0] a,
                         input logic [95:0] exp,
                         input string name);
    int w = 0;
    int lat = 0;
    bit g = 1'b0;
    bit got = 1'b0;
    logic [95:0] d = 'x;
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    while (!g && w < 50) begin
      @(negedge clock);
      g = rd_req_ready;
      tick();
      w++;
    end
    rd_req_valid = 1'b0;
    chk({name, "_grant"}, 96'(g), 96'(1));
    while (!got && lat < 50) begin
      @(negedge clock);
      lat++;
      if (rd_resp_valid) begin
        got = 1'b1;
        d = rd_resp_data;
      end
    end
    tick();
    chk({name, "_lat"}, 96'(lat), 96'(2));
    chk(name, d, exp);
  endtask

  localparam logic [95:0] A5 = {12{8'hA5}};
  localparam logic [95:0] X1 = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [95:0] X2 = 96'hFEDC_BA98_7654_3210_FFEE_DDCC;

  int          acc;
  int          nresp;
  bit          rdy;
  logic [95:0] got [4];

  initial begin
    reset_n       = 1'b0;
    rd_req_valid  = 1'b0;
    rd_req_addr   = '0;
    rd_resp_ready = 1'b1;
    wr_req_valid  = 1'b0;
    wr_req_addr   = '0;
    wr_req_mask   = '0;
    wr_req_data   = '0;

    // reset state and first sweep
    tick();
    @(negedge clock);
    chk("rst_rd_ready", 96'(rd_req_ready), 96'(0));
    chk("rst_wr_ready", 96'(wr_req_ready), 96'(0));
    chk("rst_resp_valid", 96'(rd_resp_valid), 96'(0));
    chk("rst_sram_en", 96'(sram_en), 96'(0));
    chk("rst_init_busy", 96'(init_busy), 96'(1));
    tick();
    reset_n = 1'b1;
    count_init();
    do_read(12'h000, 96'h0, "rd_000");
    do_read(12'h7FF, 96'h0, "rd_7ff");
    do_read(12'hFFF, 96'h0, "rd_fff");

    // full write then read back
    do_write(12'h123, 16'hFFFF, A5);
    do_read(12'h123, A5, "rd_a5");

    // single-lane masked write
    do_write(12'h010, 16'h0001, '1);
    do_read(12'h010, 96'h3F, "rd_lane0");

    // reset in the middle of the sweep
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (2048) @(posedge clock);
    @(negedge clock);
    chk("sweep_at_800", 96'(sram_addr), 96'(12'h800));
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    count_init();

    // contention right after the sweep
    rd_req_valid = 1'b1;
    rd_req_addr  = 12'h123;
    wr_req_valid = 1'b1;
    wr_req_addr  = 12'h200;
    wr_req_mask  = 16'hFFFF;
    wr_req_data  = X1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("arb_rd_%0d", i),
          96'(rd_req_ready), 96'(i % 2 == 0));
      chk($sformatf("arb_wr_%0d", i),
          96'(wr_req_ready), 96'(i % 2 == 1));
      chk($sformatf("arb_both_%0d", i),
          96'(rd_req_ready & wr_req_ready), 96'(0));
    end
    tick();
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    repeat (4) tick();

    // backpressure on the response side
    do_write(12'h010, 16'hFFFF, X1);
    do_write(12'h011, 16'hFFFF, X2);
    rd_resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      rd_req_valid = 1'b1;
      rd_req_addr  = 12'(16 + i);
      @(negedge clock);
      if (rd_req_ready) acc++;
      rdy = rd_req_ready;
      tick();
    end
    rd_req_valid = 1'b0;
    chk("bp_accepted", 96'(acc), 96'(2));
    chk("bp_ready_low", 96'(rdy), 96'(0));
    rd_resp_ready = 1'b1;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (rd_resp_valid) begin
        if (nresp < 4) got[nresp] = rd_resp_data;
        nresp++;
      end
      tick();
    end
    chk("bp_resp_count", 96'(nresp), 96'(2));
    chk("bp_resp_0", got[0], X1);
    chk("bp_resp_1", got[1], X2);

    // reset while responses are queued
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 12'h010;
    repeat (4) tick();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("q_held_valid", 96'(rd_resp_valid), 96'(1));
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clock);
    chk("rst_flush_valid", 96'(rd_resp_valid), 96'(0));
    chk("rst_flush_busy", 96'(init_busy), 96'(1));
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_valid", 96'(rd_resp_valid), 96'(0));
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
